lsu_bridge: RTL

//  Load/store bridge between the single-cycle core's data port and a handshaked multi-cycle data memory.

---
 rtl/lsu_bridge.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bridge.sv
// Load/store bridge: lane steering, load extension, misalignment detection and core stall
// toward a handshaked multi-cycle data memory. Optional access timeout via `define LSU_TIMEOUT_EN.
module lsu_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_re,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_done,
    output logic        core_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_lo;
    logic [2:0]  r_f3;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        w_req;
    logic [1:0]  w_size;
    logic        w_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_timeout;

    assign w_req = core_re | core_we;

    // Size code: 0 byte, 1 half, 2 word (undefined funct3 encodings fall back to word)
    always_comb begin
        w_size = 2'd2;
        case (core_funct3)
            3'b000, 3'b100: w_size = 2'd0;
            3'b001, 3'b101: w_size = 2'd1;
            default:        w_size = 2'd2;
        endcase
    end

    assign w_misalign = ((w_size == 2'd1) & core_addr[0]) |
                        ((w_size == 2'd2) & (|core_addr[1:0]));

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = core_wdata;
        case (w_size)
            2'd0: begin
                w_wstrb = 4'b0001 << core_addr[1:0];
                w_wdata = {4{core_wdata[7:0]}};
            end
            2'd1: begin
                w_wstrb = 4'b0011 << {core_addr[1], 1'b0};
                w_wdata = {2{core_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = core_wdata;
            end
        endcase
        if (!core_we)
            w_wstrb = '0;
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_lo)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] r_tmo;

    // Held at zero while idle, so it starts from zero on every IDLE->REQ
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tmo <= '0;
        else if (r_state == S_REQ || r_state == S_RESP)
            r_tmo <= r_tmo + 32'd1;
        else
            r_tmo <= '0;
    end

    assign w_timeout = (r_tmo == 32'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = |TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Completion in the timeout cycle takes priority over the abort
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = w_misalign ? S_DONE : S_REQ;
            S_REQ: begin
                if (mem_ready)      w_next = r_mem_we ? S_DONE : S_RESP;
                else if (w_timeout) w_next = S_DONE;
            end
            S_RESP: begin
                if (mem_rvalid)     w_next = S_DONE;
                else if (w_timeout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_stall = ((r_state == S_IDLE) & w_req) | (r_state == S_REQ) | (r_state == S_RESP);
        mem_valid  = (r_state == S_REQ);
        core_done  = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo        <= '0;
            r_f3        <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_lo <= core_addr[1:0];
                    r_f3 <= core_funct3;
                    if (w_misalign) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_mem_we    <= core_we;
                        r_mem_addr  <= {core_addr[31:2], 2'b00};
                        r_mem_wdata <= w_wdata;
                        r_mem_wstrb <= w_wstrb;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (r_mem_we) r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        r_rdata <= w_ext;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_rdata = r_rdata;
    assign core_err   = r_err;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;

endmodule
